// File: rtl/icache_fsm_nway.sv
// rtl/icache_fsm_nway.sv - main control FSM of the N-way L1 instruction cache
//
// Purpose:
//   Sequences lookups, burst line refills, sticky flushes and index-invalidate
//   operations. It sits between the fetch pipeline, the request buffer, the
//   TagV/Data arrays, the LRU and the memory read interface.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pipeline_icache_valid    fetch/op request valid
//   icache_pipeline_ready    cache accepts a request this cycle
//   pipeline_icache_opflag   request is an index-invalidate op
//   pipeline_icache_ctrl     [0] stall, [1] flush
//   icache_mem_req/size/len  memory burst read request (word beats)
//   mem_icache_addrOK        memory accepted the request
//   mem_icache_dataOK        one refill beat valid
//   FSM_rbuf_we              capture request into the request buffer
//   FSM_rbuf_addr            buffered address
//   FSM_hit                  per-way hit from the tag compare
//   FSM_lru_way              victim way chosen by the LRU
//   FSM_use                  one-hot LRU touch
//   FSM_Data_we              one-hot data array write enable
//   FSM_TagV_we/TagV_valid   TagV write enables and written V bit
//   FSM_refill_word          word index of the current refill beat
//   FSM_choose_way           output mux way select
//   FSM_send_nop             drive a NOP to the pipeline
//   FSM_choose_word          word select from the buffered address

module icache_fsm_nway #(
  parameter int WAY          = 2,
  parameter int WAY_W        = 1,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipeline_icache_valid,
  output logic                    icache_pipeline_ready,
  input  logic                    pipeline_icache_opflag,
  input  logic [1:0]              pipeline_icache_ctrl,
  output logic                    icache_mem_req,
  output logic [1:0]              icache_mem_size,
  output logic [7:0]              icache_mem_len,
  input  logic                    mem_icache_addrOK,
  input  logic                    mem_icache_dataOK,
  output logic                    FSM_rbuf_we,
  input  logic [31:0]             FSM_rbuf_addr,
  input  logic [WAY-1:0]          FSM_hit,
  input  logic [WAY_W-1:0]        FSM_lru_way,
  output logic [WAY-1:0]          FSM_use,
  output logic [WAY-1:0]          FSM_Data_we,
  output logic [WAY-1:0]          FSM_TagV_we,
  output logic                    FSM_TagV_valid,
  output logic [OFFSET_WIDTH-1:0] FSM_refill_word,
  output logic [WAY_W-1:0]        FSM_choose_way,
  output logic                    FSM_send_nop,
  output logic [OFFSET_WIDTH-1:0] FSM_choose_word
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_RELOOK,
    S_FLUSH,
    S_OP_INV
  } state_e;

  localparam logic [7:0]              MEM_LEN   = 8'((1 << OFFSET_WIDTH) - 1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;
  localparam logic [WAY-1:0]          WAY_ONE   = WAY'(1);

  state_e                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [WAY_W-1:0]        vict_q, vict_d;
  logic                    flush_pend_q, flush_pend_d;

  logic                    hit_any;
  logic [WAY_W-1:0]        hit_way;
  logic [WAY-1:0]          hit_oh;
  logic [WAY-1:0]          vict_oh;
  logic                    req_stall;
  logic                    req_flush;

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{FSM_rbuf_addr[31:2+OFFSET_WIDTH], FSM_rbuf_addr[1:0]};

  assign req_stall = pipeline_icache_ctrl[0];
  assign req_flush = pipeline_icache_ctrl[1];

  // Lowest-numbered hitting way wins; scanning downwards leaves the lowest.
  always_comb begin
    hit_way = '0;
    for (int i = WAY - 1; i >= 0; i--) begin
      if (FSM_hit[i]) begin
        hit_way = i[WAY_W-1:0];
      end
    end
  end

  assign hit_any = |FSM_hit;
  assign hit_oh  = WAY_ONE << hit_way;
  assign vict_oh = WAY_ONE << vict_q;

  assign FSM_choose_word = FSM_rbuf_addr[2+OFFSET_WIDTH-1:2];
  assign icache_mem_size = 2'd2;
  assign icache_mem_len  = MEM_LEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      vict_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vict_q       <= vict_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    vict_d                = vict_q;
    flush_pend_d          = flush_pend_q;
    icache_pipeline_ready = 1'b0;
    icache_mem_req        = 1'b0;
    FSM_rbuf_we           = 1'b0;
    FSM_use               = '0;
    FSM_Data_we           = '0;
    FSM_TagV_we           = '0;
    FSM_TagV_valid        = 1'b0;
    FSM_refill_word       = '0;
    FSM_choose_way        = '0;
    FSM_send_nop          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        icache_pipeline_ready = 1'b1;
        if (pipeline_icache_valid) begin
          FSM_rbuf_we = 1'b1;
          state_d     = pipeline_icache_opflag ? S_OP_INV : S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit_any) begin
          FSM_choose_way = hit_way;
          FSM_use        = hit_oh;
          if (req_flush) begin
            // The hit data is squashed; FLUSH then reopens the pipeline.
            FSM_send_nop = 1'b1;
            state_d      = S_FLUSH;
          end else if (req_stall) begin
            // Pipeline cannot take the word; hold the lookup as-is.
            state_d = S_LOOKUP;
          end else begin
            icache_pipeline_ready = 1'b1;
            if (pipeline_icache_valid) begin
              FSM_rbuf_we = 1'b1;
              state_d     = pipeline_icache_opflag ? S_OP_INV : S_LOOKUP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          vict_d       = FSM_lru_way;
          flush_pend_d = req_flush;
          state_d      = S_MISS_REQ;
        end
      end

      S_MISS_REQ: begin
        icache_mem_req = 1'b1;
        if (req_flush) begin
          flush_pend_d = 1'b1;
        end
        if (mem_icache_addrOK) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end

      S_REFILL: begin
        // A flush cannot abort the burst; remember it for after RELOOK.
        if (req_flush) begin
          flush_pend_d = 1'b1;
        end
        if (mem_icache_dataOK) begin
          FSM_Data_we     = vict_oh;
          FSM_refill_word = cnt_q;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            FSM_TagV_we    = vict_oh;
            FSM_TagV_valid = 1'b1;
            FSM_use        = vict_oh;
            state_d        = S_RELOOK;
          end
        end
      end

      S_RELOOK: begin
        // Bubble so the arrays can be re-read with the freshly written line.
        if (flush_pend_q) begin
          flush_pend_d = 1'b0;
          state_d      = S_FLUSH;
        end else begin
          state_d = S_LOOKUP;
        end
      end

      S_FLUSH: begin
        icache_pipeline_ready = 1'b1;
        FSM_send_nop          = 1'b1;
        if (pipeline_icache_valid) begin
          FSM_rbuf_we = 1'b1;
          state_d     = pipeline_icache_opflag ? S_OP_INV : S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_OP_INV: begin
        // Invalidate every way at the buffered index in one cycle.
        FSM_TagV_we    = '1;
        FSM_TagV_valid = 1'b0;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/icache_fsm_nway.md
Name: icache_fsm_nway

Overview:
- Main control FSM for the next-generation L1 instruction cache. It supports a parametrised way count and multi-word lines refilled by burst.
- Sits between the fetch pipeline, the request buffer (rbuf), the TagV/Data arrays, the LRU and the memory interface.
- Adds three things: burst line refill with a beat counter, a sticky flush that is honoured across an in-flight miss, and an index-invalidate cache operation.

Parameters:
WAY, 2, associativity; power of two, 2..8
WAY_W, 1, log2(WAY)
OFFSET_WIDTH, 2, log2(words per line); line = 2^OFFSET_WIDTH 32-bit words

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
pipeline_icache_valid  in  1  fetch request valid
icache_pipeline_ready  out  1  cache accepts a request this cycle
pipeline_icache_opflag  in  1  request is an index-invalidate op, not a fetch
pipeline_icache_ctrl  in  2  [0] stall, [1] flush
icache_mem_req  out  1  memory read request
icache_mem_size  out  2  fixed 2'd2 (word)
icache_mem_len  out  8  burst beats minus 1 = 2^OFFSET_WIDTH-1
mem_icache_addrOK  in  1  request accepted
mem_icache_dataOK  in  1  one refill beat valid
FSM_rbuf_we  out  1  capture request into rbuf
FSM_rbuf_addr  in  32  buffered address
FSM_hit  in  WAY  per-way hit
FSM_lru_way  in  WAY_W  victim way from LRU
FSM_use  out  WAY  one-hot LRU touch
FSM_Data_we  out  WAY  one-hot data write enable
FSM_TagV_we  out  WAY  TagV write enables
FSM_TagV_valid  out  1  V bit written with TagV_we
FSM_refill_word  out  OFFSET_WIDTH  word index of current refill beat
FSM_choose_way  out  WAY_W  output mux way
FSM_send_nop  out  1  drive NOP to pipeline
FSM_choose_word  out  OFFSET_WIDTH  = FSM_rbuf_addr[2+OFFSET_WIDTH-1:2] always

Behaviour:
- Registered state (reset IDLE), beat counter cnt (reset 0), victim register vict (reset 0), flush_pend (reset 0).
- All outputs are decoded combinationally from state and inputs. The default is 0 except icache_mem_size=2 and icache_mem_len constant.
- At reset the outputs are the IDLE decode: ready=1, everything else 0.
- IDLE: ready=1; valid&opflag -> OP_INV with rbuf_we=1; valid&!opflag -> LOOKUP with rbuf_we=1.
- LOOKUP:
  - Lowest set FSM_hit bit gives choose_way; FSM_use is one-hot of that way.
  - Hit & ctrl[1] -> FLUSH (ready=1, send_nop=1).
  - Hit & ctrl[0] -> stay LOOKUP, ready=0, rbuf_we=0, outputs held.
  - Hit & valid -> ready=1, rbuf_we=1, next LOOKUP or OP_INV per opflag.
  - Hit & !valid -> ready=1, next IDLE.
  - No hit -> MISS_REQ; latch vict=FSM_lru_way; flush_pend=ctrl[1].
- MISS_REQ: mem_req=1 until addrOK; addrOK -> REFILL with cnt=0.
- REFILL, per dataOK:
  - Data_we=onehot(vict), refill_word=cnt, cnt+1 (wraps mod 2^OFFSET_WIDTH).
  - On the beat with cnt==2^OFFSET_WIDTH-1: TagV_we=onehot(vict), TagV_valid=1, use=onehot(vict), next RELOOK.
  - No dataOK -> hold, no writes.
- Any ctrl[1] seen in MISS_REQ/REFILL sets flush_pend. The memory burst is never abandoned.
- RELOOK: one bubble, ready=0, rbuf_we=0. flush_pend -> FLUSH and clear flush_pend; else -> LOOKUP (re-reads arrays, guaranteed hit).
- FLUSH: ready=1, send_nop=1; valid -> rbuf_we=1, next LOOKUP/OP_INV per opflag; else IDLE.
- OP_INV: TagV_we all ones, TagV_valid=0 at rbuf index, ready=0, one cycle, -> IDLE.
- rst mid-refill: immediate IDLE, cnt=0, flush_pend=0. The memory side must drop outstanding beats.
- dataOK outside REFILL is ignored. addrOK outside MISS_REQ is ignored.

Test Plan:
- WAY=4, OFFSET_WIDTH=2; fetch 0x100 hits way 2 with valid held -> choose_way=2, use=4'b0100, ready=1 and rbuf_we=1 every cycle.
- Miss, lru_way=3, addrOK after 2 cycles, 4 dataOK with gaps:
  - Data_we=4'b1000 on each beat, refill_word 0,1,2,3.
  - TagV_we=4'b1000 with valid=1 on beat 3.
  - One RELOOK bubble, then LOOKUP hit way 3.
- ctrl[1] pulsed during the 2nd beat -> all 4 beats still written; after RELOOK, FLUSH with send_nop=1, and no hit output is delivered.
- Hit with ctrl[0]=1 for 3 cycles -> ready=0 and rbuf_we=0 for 3 cycles, choose_way stable; resumes on release.
- opflag request in IDLE -> OP_INV next cycle, TagV_we=4'b1111, TagV_valid=0, then IDLE with ready=1.
- rst asserted during beat 1 of refill -> next edge: state IDLE, ready=1, Data_we=0; a later dataOK causes no write.
